rx_engine_cfg: RTL and testbench

Runtime-configurable UART receive engine, successor to the fixed 8N1 receiver. It samples the line on the shared OSR tick with 3-sample majority voting and assembles 5–9 data bits, LSB first, with optional even/odd parity and 1 or 2 stop bits. Completed frames are written to the RX FIFO. Per-frame parity, framing, break and overrun status is pulsed for the register/interrupt block.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/rx_bit_sampler.sv | 57 +++++
 rtl/rx_engine_cfg.sv | 197 +++++++++++++++++++
 tb/tb_rx_engine_cfg.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receive path.
package uart_pkg;

   localparam int unsigned MIN_DATA_BITS = 5;
   localparam int unsigned VOTE_SAMPLES  = 3;

   typedef enum logic [1:0] {
      ParNone,
      ParEven,
      ParOdd
   } parity_mode_t;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak
   } rx_state_t;

   function automatic parity_mode_t decode_parity(input logic [1:0] cfg);
      parity_mode_t mode;
      mode = ParNone;
      case (cfg)
         2'b01:   mode = ParEven;
         2'b10:   mode = ParOdd;
         default: mode = ParNone;
      endcase
      return mode;
   endfunction

endpackage

// File: rtl/rx_bit_sampler.sv
// RX line synchroniser, oversample tick counter and 2-of-3 mid-bit majority vote.
module rx_bit_sampler #(
   parameter int unsigned OSR = 16
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_osr_tick,
   input  logic i_rx,
   input  logic i_clr,
   output logic o_rx_s,
   output logic o_vote_valid,
   output logic o_vote_bit,
   output logic o_bit_end
);

   localparam int unsigned CW = $clog2(OSR);
   localparam logic [CW-1:0] TickLast = CW'(OSR - 1);
   localparam logic [CW-1:0] Samp0    = CW'(OSR / 2 - 1);
   localparam logic [CW-1:0] Samp1    = CW'(OSR / 2);
   localparam logic [CW-1:0] Samp2    = CW'(OSR / 2 + 1);

   logic          r_sync;
   logic          r_rx_s;
   logic [CW-1:0] r_tick_cnt;
   logic          r_s0;
   logic          r_s1;
   logic          w_bit_end;

   assign w_bit_end = i_osr_tick && (r_tick_cnt == TickLast);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync     <= 1'b0;
         r_rx_s     <= 1'b0;
         r_tick_cnt <= '0;
         r_s0       <= 1'b0;
         r_s1       <= 1'b0;
      end else begin
         r_sync <= i_rx;
         r_rx_s <= r_sync;
         if (i_clr) begin
            r_tick_cnt <= '0;
         end else if (i_osr_tick) begin
            r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + 1'b1;
            if (r_tick_cnt == Samp0) r_s0 <= r_rx_s;
            if (r_tick_cnt == Samp1) r_s1 <= r_rx_s;
         end
      end
   end

   // Third sample is the live synchronised line on the vote tick itself.
   assign o_vote_valid = i_osr_tick && !i_clr && (r_tick_cnt == Samp2);
   assign o_vote_bit   = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
   assign o_bit_end    = w_bit_end && !i_clr;
   assign o_rx_s       = r_rx_s;

endmodule

// File: rtl/rx_engine_cfg.sv
// Runtime-configurable UART receiver: 5..9 data bits, optional parity, 1 or 2 stop bits.
module rx_engine_cfg
   import uart_pkg::*;
#(
   parameter int unsigned OSR           = 16,
   parameter int unsigned MAX_DATA_BITS = 9
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     osr_tick_i,
   input  logic                     recieve_bit_i,
   input  logic                     rx_en_i,
   input  logic [3:0]               cfg_data_bits_i,
   input  logic [1:0]               cfg_parity_i,
   input  logic                     cfg_stop_bits_i,
   input  logic                     rx_fifo_full_i,
   output logic [MAX_DATA_BITS-1:0] rx_fifo_data_o,
   output logic                     rx_fifo_wen_o,
   output logic                     rx_busy_o,
   output logic                     parity_err_o,
   output logic                     frame_err_o,
   output logic                     break_o,
   output logic                     overrun_err_o
);

   localparam logic [3:0] MinBits = 4'(MIN_DATA_BITS);
   localparam logic [3:0] MaxBits = 4'(MAX_DATA_BITS);

   rx_state_t                r_state;
   parity_mode_t             r_par;
   logic                     r_armed;
   logic [3:0]               r_nbits;
   logic                     r_stop2;
   logic [3:0]               r_bit_cnt;
   logic [MAX_DATA_BITS-1:0] r_shift;
   logic                     r_par_bad;
   logic                     r_frm_bad;
   logic                     r_par_bit;
   logic                     r_stop1_zero;
   logic [MAX_DATA_BITS-1:0] r_fifo_data;
   logic                     r_wen;
   logic                     r_perr;
   logic                     r_ferr;
   logic                     r_brk;
   logic                     r_ovr;

   logic       w_rx_s;
   logic       w_vote_valid;
   logic       w_vote_bit;
   logic       w_bit_end;
   logic       w_clr;
   logic [3:0] w_cfg_bits;
   logic       w_par_exp;
   logic       w_stop_final;
   logic       w_stop1_zero;
   logic       w_frm;
   logic       w_break;

   assign w_clr = (r_state == StIdle) || (r_state == StBreak);

   rx_bit_sampler #(
      .OSR (OSR)
   ) u_sampler (
      .i_clk        (clk_i),
      .i_reset      (reset_i),
      .i_osr_tick   (osr_tick_i),
      .i_rx         (recieve_bit_i),
      .i_clr        (w_clr),
      .o_rx_s       (w_rx_s),
      .o_vote_valid (w_vote_valid),
      .o_vote_bit   (w_vote_bit),
      .o_bit_end    (w_bit_end)
   );

   assign w_cfg_bits   = (cfg_data_bits_i < MinBits) ? MinBits :
                         (cfg_data_bits_i > MaxBits) ? MaxBits : cfg_data_bits_i;
   assign w_par_exp    = (^r_shift) ^ (r_par == ParOdd);
   assign w_stop_final = !r_stop2 || (r_bit_cnt == 4'd1);
   assign w_stop1_zero = (r_bit_cnt == 4'd0) ? !w_vote_bit : r_stop1_zero;
   assign w_frm        = r_frm_bad || !w_vote_bit;
   assign w_break      = (r_shift == '0) && !((r_par != ParNone) && r_par_bit) && w_stop1_zero;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state      <= StIdle;
         r_par        <= ParNone;
         r_armed      <= 1'b0;
         r_nbits      <= '0;
         r_stop2      <= 1'b0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_par_bad    <= 1'b0;
         r_frm_bad    <= 1'b0;
         r_par_bit    <= 1'b0;
         r_stop1_zero <= 1'b0;
         r_fifo_data  <= '0;
         r_wen        <= 1'b0;
         r_perr       <= 1'b0;
         r_ferr       <= 1'b0;
         r_brk        <= 1'b0;
         r_ovr        <= 1'b0;
      end else begin
         r_wen  <= 1'b0;
         r_perr <= 1'b0;
         r_ferr <= 1'b0;
         r_brk  <= 1'b0;
         r_ovr  <= 1'b0;
         if (!rx_en_i) r_armed <= 1'b0;
         if ((r_state != StIdle) && !rx_en_i) begin
            r_state <= StIdle;
         end else begin
            unique case (r_state)
               StIdle: begin
                  // Arming on a high line means a line held low at enable is ignored.
                  if (rx_en_i && w_rx_s) r_armed <= 1'b1;
                  if (rx_en_i && r_armed && !w_rx_s) begin
                     r_state      <= StStart;
                     r_nbits      <= w_cfg_bits;
                     r_par        <= decode_parity(cfg_parity_i);
                     r_stop2      <= cfg_stop_bits_i;
                     r_bit_cnt    <= '0;
                     r_shift      <= '0;
                     r_par_bad    <= 1'b0;
                     r_frm_bad    <= 1'b0;
                     r_par_bit    <= 1'b0;
                     r_stop1_zero <= 1'b0;
                  end
               end
               StStart: begin
                  if (w_vote_valid && w_vote_bit) r_state <= StIdle;
                  else if (w_bit_end)             r_state <= StData;
               end
               StData: begin
                  if (w_vote_valid) r_shift[r_bit_cnt] <= w_vote_bit;
                  if (w_bit_end) begin
                     if (r_bit_cnt == r_nbits - 4'd1) begin
                        r_bit_cnt <= '0;
                        r_state   <= (r_par == ParNone) ? StStop : StParity;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                     end
                  end
               end
               StParity: begin
                  if (w_vote_valid) begin
                     r_par_bit <= w_vote_bit;
                     if (w_vote_bit != w_par_exp) r_par_bad <= 1'b1;
                  end
                  if (w_bit_end) r_state <= StStop;
               end
               StStop: begin
                  if (w_vote_valid) begin
                     r_stop1_zero <= w_stop1_zero;
                     if (!w_vote_bit) r_frm_bad <= 1'b1;
                     // Decide on the last stop vote so back-to-back frames have half a bit of slack.
                     if (w_stop_final) begin
                        if (w_break) begin
                           r_brk   <= 1'b1;
                           r_state <= StBreak;
                        end else begin
                           r_state <= StIdle;
                           if (w_frm) begin
                              r_ferr <= 1'b1;
                           end else if (rx_fifo_full_i) begin
                              r_ovr <= 1'b1;
                           end else begin
                              r_wen       <= 1'b1;
                              r_fifo_data <= r_shift;
                              r_perr      <= r_par_bad;
                           end
                        end
                     end
                  end else if (w_bit_end) begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end
               StBreak: begin
                  if (w_rx_s) begin
                     r_state <= StIdle;
                     r_armed <= 1'b1;
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign rx_busy_o      = (r_state != StIdle);
   assign rx_fifo_data_o = r_fifo_data;
   assign rx_fifo_wen_o  = r_wen;
   assign parity_err_o   = r_perr;
   assign frame_err_o    = r_ferr;
   assign break_o        = r_brk;
   assign overrun_err_o  = r_ovr;

endmodule

// File: tb/tb_rx_engine_cfg.sv
// Directed bench for rx_engine_cfg with a frame-level scoreboard of expected completion pulses.
module tb_rx_engine_cfg;

   localparam int OSR = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic       line;
   logic       rx_en;
   logic       full;
   logic [3:0] cfg_bits;
   logic [1:0] cfg_par;
   logic       cfg_s2;
   logic [8:0] data_o;
   logic       wen, busy, perr, ferr, brk, ovr;

   typedef struct packed {
      logic       wen;
      logic [8:0] data;
      logic       perr;
      logic       ferr;
      logic       brk;
      logic       ovr;
   } exp_t;

   exp_t       q[$];
   exp_t       mon_e;
   logic [8:0] last_data;
   int         n_vec = 0;
   int         n_err = 0;
   int         div = 0;

   always #5 clk = ~clk;

   rx_engine_cfg #(
      .OSR           (OSR),
      .MAX_DATA_BITS (9)
   ) dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .osr_tick_i      (tick),
      .recieve_bit_i   (line),
      .rx_en_i         (rx_en),
      .cfg_data_bits_i (cfg_bits),
      .cfg_parity_i    (cfg_par),
      .cfg_stop_bits_i (cfg_s2),
      .rx_fifo_full_i  (full),
      .rx_fifo_data_o  (data_o),
      .rx_fifo_wen_o   (wen),
      .rx_busy_o       (busy),
      .parity_err_o    (perr),
      .frame_err_o     (ferr),
      .break_o         (brk),
      .overrun_err_o   (ovr)
   );

   // Oversample strobe: one cycle in every four.
   initial begin
      tick = 1'b0;
      forever begin
         @(negedge clk);
         div  = (div == 3) ? 0 : div + 1;
         tick = (div == 3);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not reach its end");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && (wen | perr | ferr | brk | ovr)) begin
         check("pulse_expected", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            mon_e = q.pop_front();
            check("frame_result", 32'({wen, data_o, perr, ferr, brk, ovr}), 32'(mon_e));
         end
      end
   end

   task automatic wait_tick();
      do @(posedge clk); while (!tick);
   endtask

   task automatic idle(input int n);
      #1 line = 1'b1;
      repeat (n) wait_tick();
   endtask

   task automatic send(input logic [15:0] b, input int n, input int gl, input logic chk,
                       input logic busy_exp);
      for (int i = 0; i < n; i++) begin
         for (int t = 1; t <= OSR; t++) begin
            #1 line = (i == gl && t == OSR / 2 + 1) ? ~b[i] : b[i];
            wait_tick();
            if (chk && i == n - 1 && t == OSR / 2 + 2) begin
               #1;
               check("pulse_timing", 32'(wen | perr | ferr | brk | ovr), 32'd1);
               check("busy_after_frame", 32'(busy), 32'(busy_exp));
            end
         end
      end
   endtask

   // Decodes the line bit stream the way a receiver is expected to.
   function automatic exp_t model(input logic [15:0] b, input int nd, input logic [1:0] par,
                                  input logic s2, input logic fl, input logic [8:0] last);
      exp_t       e;
      logic [8:0] d;
      logic       pen, pbit, pbad, st1, st2;
      int         k;
      d = '0;
      for (int i = 0; i < nd; i++) d[i] = b[1 + i];
      pen  = (par == 2'b01) || (par == 2'b10);
      k    = 1 + nd;
      pbit = pen ? b[k] : 1'b0;
      pbad = pen && (pbit != ((^d) ^ (par == 2'b10)));
      if (pen) k++;
      st1 = b[k];
      st2 = s2 ? b[k + 1] : 1'b1;
      e = '0;
      e.data = last;
      if (d == '0 && !pbit && !st1) e.brk = 1'b1;
      else if (!st1 || !st2)        e.ferr = 1'b1;
      else if (fl)                  e.ovr = 1'b1;
      else begin
         e.wen  = 1'b1;
         e.data = d;
         e.perr = pbad;
      end
      return e;
   endfunction

   task automatic build(input logic [8:0] d, input int nd, input logic flip, input logic stop_v,
                        output logic [15:0] b, output int n);
      int   k;
      logic p;
      b = '0;
      p = 1'b0;
      for (int i = 0; i < nd; i++) begin
         b[1 + i] = d[i];
         p        = p ^ d[i];
      end
      k = 1 + nd;
      if (cfg_par == 2'b01 || cfg_par == 2'b10) begin
         b[k] = p ^ (cfg_par == 2'b10) ^ flip;
         k++;
      end
      b[k] = stop_v;
      if (cfg_s2) begin
         k++;
         b[k] = 1'b1;
      end
      n = k + 1;
   endtask

   task automatic run_frame(input logic [8:0] d, input int nd, input logic flip,
                            input logic stop_v, input int gl);
      logic [15:0] b;
      int          n;
      exp_t        e;
      build(d, nd, flip, stop_v, b, n);
      e = model(b, nd, cfg_par, cfg_s2, full, last_data);
      q.push_back(e);
      if (e.wen) last_data = e.data;
      send(b, n, gl, 1'b1, e.brk);
   endtask

   task automatic cfg(input logic [3:0] nb, input logic [1:0] p, input logic s2);
      cfg_bits = nb;
      cfg_par  = p;
      cfg_s2   = s2;
   endtask

   initial begin
      logic [15:0] b;
      int          n;
      reset     = 1'b1;
      line      = 1'b1;
      rx_en     = 1'b1;
      full      = 1'b0;
      last_data = '0;
      cfg(4'd8, 2'b00, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 32'({wen, perr, ferr, brk, ovr, busy}), 32'd0);
      check("reset_data", 32'(data_o), 32'd0);
      reset = 1'b0;
      idle(32);

      run_frame(9'h0AA, 8, 1'b0, 1'b1, -1);

      cfg(4'd7, 2'b01, 1'b1);
      run_frame(9'h055, 7, 1'b1, 1'b1, -1);
      run_frame(9'h055, 7, 1'b0, 1'b1, -1);

      cfg(4'd9, 2'b10, 1'b0);
      run_frame(9'h1FF, 9, 1'b0, 1'b1, 4);
      idle(16);

      // Start bit only 4 ticks long.
      #1 line = 1'b0;
      repeat (4) wait_tick();
      idle(32);
      check("false_start_idle", 32'(busy), 32'd0);
      cfg(4'd5, 2'b00, 1'b0);
      run_frame(9'h013, 5, 1'b0, 1'b1, -1);
      idle(16);

      cfg(4'd8, 2'b00, 1'b0);
      run_frame(9'h05A, 8, 1'b0, 1'b0, -1);
      idle(32);

      run_frame(9'h000, 8, 1'b0, 1'b0, -1);
      repeat (10 * OSR) wait_tick();
      check("busy_in_break", 32'(busy), 32'd1);
      #1 line = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("busy_after_break", 32'(busy), 32'd0);
      idle(32);

      full = 1'b1;
      run_frame(9'h03C, 8, 1'b0, 1'b1, -1);
      full = 1'b0;
      idle(16);

      cfg(4'd2, 2'b10, 1'b1);
      run_frame(9'h00B, 5, 1'b0, 1'b1, -1);
      cfg(4'd15, 2'b00, 1'b0);
      run_frame(9'h101, 9, 1'b0, 1'b1, -1);
      idle(16);

      cfg(4'd8, 2'b00, 1'b0);
      build(9'h0FF, 8, 1'b0, 1'b1, b, n);
      send(b, 4, -1, 1'b0, 1'b0);
      check("busy_mid_data", 32'(busy), 32'd1);
      #1 rx_en = 1'b0;
      @(posedge clk);
      #1;
      check("busy_after_disable", 32'(busy), 32'd0);
      idle(32);
      rx_en = 1'b1;
      idle(32);

      send(b, 5, -1, 1'b0, 1'b0);
      check("busy_before_reset", 32'(busy), 32'd1);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      check("midframe_reset_outputs", 32'({wen, perr, ferr, brk, ovr, busy}), 32'd0);
      check("midframe_reset_data", 32'(data_o), 32'd0);
      last_data = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      idle(32);

      run_frame(9'h0C3, 8, 1'b0, 1'b1, -1);
      idle(32);
      check("scoreboard_drained", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
